byte_mem_responder: RTL
=======================

BYTE_MEM_RESPONDER -- requirements
Module: byte_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 12: byte array size is 2^DEPTH_LOG2 bytes.
REQ-002 The block SHALL have parameter WP_LIMIT, default 32'h0000_0100: addresses below this value are write-protected.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port mem_use, input, 1 bit: initiator owns the bus this cycle.
REQ-006 The block SHALL have port mem_addr, input, 32 bits: byte address.
REQ-007 The block SHALL have port mem_write, input, 1 bit: write beat.
REQ-008 The block SHALL have port mem_read, input, 1 bit: read beat.
REQ-009 The block SHALL have port mem_wdata, input, 8 bits: write byte.
REQ-010 The block SHALL have port mem_rdata, output, 8 bits: read byte, combinational.
REQ-011 The block SHALL have port burst_done, output, 1 bit: one-cycle pulse after the 4th beat.
REQ-012 The block SHALL have port err_clear, input, 1 bit: clears the sticky error flags.
REQ-013 The block SHALL have port err_align, output, 1 bit: sticky flag, burst base not 4-byte aligned.
REQ-014 The block SHALL have port err_seq, output, 1 bit: sticky flag, beat address, direction or length violation.
REQ-015 The block SHALL have port err_range, output, 1 bit: sticky flag, address >= 2^DEPTH_LOG2.
REQ-016 The block SHALL have port err_wp, output, 1 bit: sticky flag, write attempted below WP_LIMIT.
REQ-017 The block SHALL have port rd_count, output, 16 bits: read beats serviced, saturating.
REQ-018 The block SHALL have port wr_count, output, 16 bits: write beats serviced, saturating.

Function
REQ-019 The block SHALL define a beat as a rising clk edge with mem_use=1.
REQ-020 The block SHALL drive mem_rdata = mem[mem_addr[DEPTH_LOG2-1:0]] combinationally when mem_use & mem_read & in range, and 8'h00 otherwise.
REQ-021 The block SHALL write mem_wdata on a beat with mem_write=1 only if the address is in range and >= WP_LIMIT; otherwise the array SHALL be left unchanged.
REQ-022 The block SHALL implement the FSM IDLE/ACTIVE with a 2-bit beat counter and a 32-bit base register.
REQ-023 On a beat in IDLE, the block SHALL capture the base address and direction, set err_align if mem_addr[1:0] != 0, set the beat counter to 1 and enter ACTIVE.
REQ-024 On a beat in ACTIVE, the block SHALL set err_seq if mem_addr != base + count or the direction differs from the captured direction, and then increment the count.
REQ-025 On the beat where count==3, the block SHALL return to IDLE with count 0 and assert burst_done for exactly the following cycle.
REQ-026 On an edge in ACTIVE with mem_use=0 (short burst), the block SHALL set err_seq and return to IDLE; burst_done SHALL NOT be asserted.
REQ-027 If mem_use stays high after the 4th beat, the next beat SHALL start a new burst (back-to-back), with no error.
REQ-028 A beat with both mem_read and mem_write high, or with neither high, SHALL set err_seq, perform no write, and count nothing.
REQ-029 The block SHALL increment rd_count and wr_count once per valid beat of the matching direction, saturating at 16'hFFFF; errored beats SHALL still be counted.
REQ-030 Errored beats SHALL still be counted; the only exception is an illegal read/write combination (REQ-028), which counts nothing.
REQ-031 err_range and err_wp SHALL be set on the offending beat.
REQ-032 Error flags SHALL be sticky until err_clear is sampled high; if a new error occurs on the same edge as err_clear, the set SHALL win.
REQ-033 All outputs except mem_rdata SHALL be registered.

Reset
REQ-034 Reset SHALL asynchronously force: state IDLE, count 0, base 0, burst_done 0, all error flags 0, rd_count and wr_count 0.
REQ-035 Reset SHALL NOT clear the byte array; the array SHALL be zero-initialised at simulation start.
REQ-036 Reset asserted mid-burst SHALL abandon the burst without raising any error; the first beat after reset release SHALL be treated as a new base.

Structure
REQ-037 The shared package SHALL hold the FSM state encoding, the BEATS_PER_WORD=4 constant and the counter width (16).
REQ-038 The block SHALL contain one sub-module, byte_mem_array: the 2^DEPTH_LOG2 x 8 array with asynchronous read and synchronous write-enable.

Verification
REQ-039 Four write beats to 0x200..0x203 with data 0x11,0x22,0x33,0x44, then four read beats -> mem_rdata returns 0x11,0x22,0x33,0x44; burst_done pulses twice; wr_count=4, rd_count=4; no errors.
REQ-040 A 4-beat write at 0x0080 -> array unchanged, err_wp=1, wr_count=4; err_clear pulse -> err_wp=0.
REQ-041 A burst at 0x202 -> err_align=1; a burst with beat 2 at 0x20A instead of 0x202 -> err_seq=1.
REQ-042 mem_use dropped after 2 beats -> err_seq=1, no burst_done, state IDLE; the next burst at 0x300 completes cleanly.
REQ-043 A read at 0x1000 with DEPTH_LOG2=12 -> mem_rdata=0x00, err_range=1.
REQ-044 Reset asserted after beat 1 -> flags 0, counters 0, data previously written retained; rd_count preloaded to 0xFFFF and then read once -> stays 0xFFFF.

Source files
------------

// File: rtl/byte_mem_responder_pkg.sv
// Shared definitions for the byte memory responder: burst FSM encoding,
// burst length, counter width and the saturating increment helper.
package byte_mem_responder_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam int BEATS_PER_WORD = 4;
    localparam int CNT_W          = 16;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_WORD - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/byte_mem_array.sv
// Byte-wide storage: asynchronous read, synchronous write-enable.
// Contents are not reset; they start at zero and survive block resets.
module byte_mem_array
    import byte_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem_r [2**DEPTH_LOG2] = '{default: 8'h00};

    // Single write port; the enable already folds in range and protection
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/byte_mem_responder.sv
// Four-beat burst responder in front of a byte array: tracks burst sequencing,
// flags protocol/range/protection errors and counts serviced beats.
module byte_mem_responder
    import byte_mem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] WP_LIMIT   = 32'h0000_0100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_use,
    input  logic [31:0]      mem_addr,
    input  logic             mem_write,
    input  logic             mem_read,
    input  logic [7:0]       mem_wdata,
    output logic [7:0]       mem_rdata,
    output logic             burst_done,
    input  logic             err_clear,
    output logic             err_align,
    output logic             err_seq,
    output logic             err_range,
    output logic             err_wp,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam logic [32:0] ADDR_SPAN = 33'd1 << DEPTH_LOG2;

    state_t           state_r;
    logic [1:0]       count_r;
    logic [31:0]      base_r;
    logic             dir_r;
    logic             burst_done_r;
    logic             err_align_r, err_seq_r, err_range_r, err_wp_r;
    logic [CNT_W-1:0] rd_count_r, wr_count_r;

    logic       in_range_s, rd_beat_s, wr_beat_s, illegal_s, we_s, active_s;
    logic       align_set_s, seq_set_s, range_set_s, wp_set_s;
    logic [7:0] array_rdata_s;

    // Beat decode, error detection and the combinational read path
    always_comb begin
        active_s    = (state_r == ST_ACTIVE);
        in_range_s  = ({1'b0, mem_addr} < ADDR_SPAN);
        rd_beat_s   = mem_use & mem_read & ~mem_write;
        wr_beat_s   = mem_use & mem_write & ~mem_read;
        illegal_s   = mem_use & (mem_read == mem_write);
        we_s        = wr_beat_s & in_range_s & (mem_addr >= WP_LIMIT);
        align_set_s = mem_use & ~active_s & (mem_addr[1:0] != 2'b00);
        // A dropped mem_use mid-burst is a short burst; otherwise check address and direction
        seq_set_s   = illegal_s
                    | (active_s & (~mem_use
                                   | (mem_addr != (base_r + {30'd0, count_r}))
                                   | (mem_write != dir_r)));
        range_set_s = mem_use & ~in_range_s;
        wp_set_s    = wr_beat_s & (mem_addr < WP_LIMIT);
        if (mem_use && mem_read && in_range_s) begin
            mem_rdata = array_rdata_s;
        end else begin
            mem_rdata = 8'h00;
        end
    end

    // Burst FSM: capture base/direction on the first beat, close after the fourth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            count_r      <= 2'd0;
            base_r       <= 32'h0000_0000;
            dir_r        <= 1'b0;
            burst_done_r <= 1'b0;
        end else begin
            burst_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (mem_use) begin
                        base_r  <= mem_addr;
                        dir_r   <= mem_write;
                        count_r <= 2'd1;
                        state_r <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (!mem_use) begin
                        count_r <= 2'd0;
                        state_r <= ST_IDLE;
                    end else if (count_r == LAST_BEAT) begin
                        count_r      <= 2'd0;
                        state_r      <= ST_IDLE;
                        burst_done_r <= 1'b1;
                    end else begin
                        count_r <= count_r + 2'd1;
                    end
                end
                default: begin
                    count_r <= 2'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new error on the clearing edge wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_align_r <= 1'b0;
            err_seq_r   <= 1'b0;
            err_range_r <= 1'b0;
            err_wp_r    <= 1'b0;
        end else begin
            err_align_r <= align_set_s | (err_align_r & ~err_clear);
            err_seq_r   <= seq_set_s   | (err_seq_r   & ~err_clear);
            err_range_r <= range_set_s | (err_range_r & ~err_clear);
            err_wp_r    <= wp_set_s    | (err_wp_r    & ~err_clear);
        end
    end

    // Saturating beat counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_r <= {CNT_W{1'b0}};
            wr_count_r <= {CNT_W{1'b0}};
        end else begin
            if (rd_beat_s) begin
                rd_count_r <= sat_inc(rd_count_r);
            end
            if (wr_beat_s) begin
                wr_count_r <= sat_inc(wr_count_r);
            end
        end
    end

    byte_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .addr  (mem_addr[DEPTH_LOG2-1:0]),
        .wdata (mem_wdata),
        .rdata (array_rdata_s)
    );

    assign burst_done = burst_done_r;
    assign err_align  = err_align_r;
    assign err_seq    = err_seq_r;
    assign err_range  = err_range_r;
    assign err_wp     = err_wp_r;
    assign rd_count   = rd_count_r;
    assign wr_count   = wr_count_r;

endmodule
